// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 mouse packet tracker: FSM encoding,
// special device bytes and bit positions inside packet byte 0.
package ps2_pkg;
   localparam logic [1:0] ST_WAIT_B0 = 2'd0;
   localparam logic [1:0] ST_WAIT_B1 = 2'd1;
   localparam logic [1:0] ST_WAIT_B2 = 2'd2;
   localparam logic [1:0] ST_APPLY   = 2'd3;

   typedef enum logic [1:0] {
      WAIT_B0 = ST_WAIT_B0,
      WAIT_B1 = ST_WAIT_B1,
      WAIT_B2 = ST_WAIT_B2,
      APPLY   = ST_APPLY
   } state_t;

   localparam logic [7:0] PS2_ACK = 8'hFA;
   localparam logic [7:0] PS2_BAT = 8'hAA;

   localparam int YOVF = 7;
   localparam int XOVF = 6;
   localparam int YSGN = 5;
   localparam int XSGN = 4;
   localparam int SYNC = 3;
endpackage

// File: rtl/ps2_axis_clamp.sv
// One cursor axis: pos +/- delta, saturated to [0, max]. Purely combinational.
module ps2_axis_clamp #(
   parameter int COORD_W = 8
) (
   input  logic [COORD_W-1:0] pos,
   input  logic signed [8:0]  delta,
   input  logic               sub,
   input  logic [COORD_W-1:0] max,
   output logic [COORD_W-1:0] nxt
);
   localparam int W = COORD_W + 2;

   logic signed [W-1:0] p, d, m, s;

   // Two guard bits hold both the full 9-bit delta range and the sign.
   always_comb begin
      p = signed'({2'b00, pos});
      d = W'(delta);
      m = signed'({2'b00, max});
      s = sub ? (p - d) : (p + d);
      if (s < 0)
         nxt = '0;
      else if (s > m)
         nxt = max;
      else
         nxt = s[COORD_W-1:0];
   end
endmodule

// File: rtl/ps2_mouse_tracker.sv
// Frames 3-byte PS/2 mouse packets from PS2_Controller, decodes buttons and
// motion, and integrates motion into a clamped cursor position.
module ps2_mouse_tracker
   import ps2_pkg::*;
#(
   parameter int COORD_W        = 8,
   parameter int X_MAX          = 159,
   parameter int Y_MAX          = 119,
   parameter int X_INIT         = 80,
   parameter int Y_INIT         = 60,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic               CLOCK_50,
   input  logic               resetn,
   input  logic [7:0]         received_data,
   input  logic               received_data_en,
   input  logic               stream_enable,
   output logic [2:0]         buttons,
   output logic [8:0]         dx,
   output logic [8:0]         dy,
   output logic [COORD_W-1:0] cursor_x,
   output logic [COORD_W-1:0] cursor_y,
   output logic               packet_valid,
   output logic               sync_error
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   state_t        state;
   logic [TW-1:0] tcnt;
   logic [2:0]    b0_btn;
   logic          b0_xovf, b0_yovf, b0_xsgn, b0_ysgn;
   logic [7:0]    b1;
   logic signed [8:0]  dx_n, dy_n;
   logic [COORD_W-1:0] x_n, y_n;
   logic          drop_b0, timeout;

   // Byte 2 is taken straight off the bus so the result lands one cycle
   // after the third strobe.
   always_comb begin
      dx_n    = b0_xovf ? 9'sd0 : signed'({b0_xsgn, b1});
      dy_n    = b0_yovf ? 9'sd0 : signed'({b0_ysgn, received_data});
      drop_b0 = (received_data == PS2_ACK) || (received_data == PS2_BAT);
      timeout = (tcnt == TW'(TIMEOUT_CYCLES - 1));
   end

   ps2_axis_clamp #(.COORD_W(COORD_W)) u_clamp_x (
      .pos(cursor_x), .delta(dx_n), .sub(1'b0), .max(COORD_W'(X_MAX)), .nxt(x_n)
   );

   // Mouse-up is positive but screen-down is positive, so Y subtracts.
   ps2_axis_clamp #(.COORD_W(COORD_W)) u_clamp_y (
      .pos(cursor_y), .delta(dy_n), .sub(1'b1), .max(COORD_W'(Y_MAX)), .nxt(y_n)
   );

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state        <= WAIT_B0;
         tcnt         <= '0;
         b0_btn       <= '0;
         b0_xovf      <= 1'b0;
         b0_yovf      <= 1'b0;
         b0_xsgn      <= 1'b0;
         b0_ysgn      <= 1'b0;
         b1           <= '0;
         buttons      <= '0;
         dx           <= '0;
         dy           <= '0;
         cursor_x     <= COORD_W'(X_INIT);
         cursor_y     <= COORD_W'(Y_INIT);
         packet_valid <= 1'b0;
         sync_error   <= 1'b0;
      end else begin
         packet_valid <= 1'b0;
         sync_error   <= 1'b0;
         if (!stream_enable) begin
            state <= WAIT_B0;
            tcnt  <= '0;
         end else begin
            case (state)
               WAIT_B0: begin
                  tcnt <= '0;
                  if (received_data_en && !drop_b0) begin
                     if (received_data[SYNC]) begin
                        b0_btn  <= received_data[2:0];
                        b0_xovf <= received_data[XOVF];
                        b0_yovf <= received_data[YOVF];
                        b0_xsgn <= received_data[XSGN];
                        b0_ysgn <= received_data[YSGN];
                        state   <= WAIT_B1;
                     end else begin
                        sync_error <= 1'b1;
                     end
                  end
               end
               WAIT_B1: begin
                  if (received_data_en) begin
                     b1    <= received_data;
                     tcnt  <= '0;
                     state <= WAIT_B2;
                  end else if (timeout) begin
                     tcnt       <= '0;
                     sync_error <= 1'b1;
                     state      <= WAIT_B0;
                  end else begin
                     tcnt <= tcnt + TW'(1);
                  end
               end
               WAIT_B2: begin
                  if (received_data_en) begin
                     tcnt         <= '0;
                     buttons      <= b0_btn;
                     dx           <= dx_n;
                     dy           <= dy_n;
                     cursor_x     <= x_n;
                     cursor_y     <= y_n;
                     packet_valid <= 1'b1;
                     state        <= APPLY;
                  end else if (timeout) begin
                     tcnt       <= '0;
                     sync_error <= 1'b1;
                     state      <= WAIT_B0;
                  end else begin
                     tcnt <= tcnt + TW'(1);
                  end
               end
               default: begin
                  tcnt  <= '0;
                  state <= WAIT_B0;
               end
            endcase
         end
      end
   end
endmodule
